// File: rtl/prio_pkg.sv
// Shared types and helpers for the sequential priority request server.
package prio_pkg;

    typedef enum logic {
        PRIO_IDLE  = 1'b0,
        PRIO_SERVE = 1'b1
    } prio_state_e;

    // Helpers take a 64-bit vector so any WIDTH up to 64 can zero-extend into them.
    localparam int PRIO_MAX_WIDTH = 64;

    function automatic logic [5:0] prio_msb_idx(input logic [PRIO_MAX_WIDTH-1:0] vec);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < PRIO_MAX_WIDTH; i++) begin
            if (vec[i]) r = 6'(i);
        end
        return r;
    endfunction

    function automatic logic prio_is_onehot(input logic [PRIO_MAX_WIDTH-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < PRIO_MAX_WIDTH; i++) begin
            if (vec[i]) cnt++;
        end
        return (cnt == 1);
    endfunction

endpackage

// File: rtl/prio_enc_msb.sv
// Combinational MSB-first priority encoder: index, one-hot grant and any-set flag.
module prio_enc_msb
    import prio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] grant,
    output logic             any_set
);

    always_comb begin
        any_set = |vec;
        idx     = IDXW'(prio_msb_idx(64'(vec)));
        grant   = any_set ? (WIDTH'(1) << idx) : '0;
    end

endmodule

// File: rtl/prio_req_server.sv
// Latches a request vector and serves its set bits MSB-first, one per output handshake.
// Optional sticky zero-vector flag via `define PRIO_ZERO_ERR_EN.
module prio_req_server
    import prio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last,
    output logic             busy
`ifdef PRIO_ZERO_ERR_EN
    ,
    output logic             zero_err
`endif
);

    localparam logic [0:0] ST_IDLE  = PRIO_IDLE;
    localparam logic [0:0] ST_SERVE = PRIO_SERVE;

    logic [0:0]       state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] grant;
    logic             any_set;
    logic             in_fire;
    logic             out_fire;

    prio_enc_msb #(.WIDTH(WIDTH), .IDXW(IDXW)) u_enc (
        .vec     (pending),
        .idx     (out_idx),
        .grant   (grant),
        .any_set (any_set)
    );

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and in_ready only looks ahead to a completing last index.
    always_comb begin
        out_valid = (state == ST_SERVE);
        busy      = any_set;
        out_last  = (state == ST_SERVE) && prio_is_onehot(64'(pending));
        in_ready  = (state == ST_IDLE) || ((state == ST_SERVE) && out_last && out_ready);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pending <= '0;
        end else begin
            if (out_fire) begin
                if (out_last) begin
                    state   <= ST_IDLE;
                    pending <= '0;
                end else begin
                    pending <= pending & ~grant;
                end
            end
            // A new vector overrides the retirement of the last index in the same cycle.
            if (in_fire) begin
                if (in_req != '0) begin
                    state   <= ST_SERVE;
                    pending <= in_req;
                end else begin
                    state   <= ST_IDLE;
                    pending <= '0;
                end
            end
        end
    end

`ifdef PRIO_ZERO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_err <= 1'b0;
        end else if (in_fire && (in_req == '0)) begin
            zero_err <= 1'b1;
`ifndef SYNTHESIS
            $error("prio_req_server: all-zero request vector accepted");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_prio_req_server.sv
// Directed bench for prio_req_server (WIDTH 8 and 16 instances) with an expected-index queue.
module tb_prio_req_server;

    logic clk;
    logic rst;

    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, busy8;
    logic [7:0] in_req8;
    logic [2:0] out_idx8;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, busy16;
    logic [15:0] in_req16;
    logic [3:0]  out_idx16;

`ifdef PRIO_ZERO_ERR_EN
    logic zero_err8, zero_err16;
`endif

    // {last, idx} for each index still owed by the WIDTH=8 instance
    logic [3:0] exp_q[$];

    int tests_run;
    int tests_failed;

    prio_req_server #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_req    (in_req8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_idx   (out_idx8),
        .out_last  (out_last8),
        .busy      (busy8)
`ifdef PRIO_ZERO_ERR_EN
        ,
        .zero_err  (zero_err8)
`endif
    );

    prio_req_server #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .in_req    (in_req16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .out_idx   (out_idx16),
        .out_last  (out_last16),
        .busy      (busy16)
`ifdef PRIO_ZERO_ERR_EN
        ,
        .zero_err  (zero_err16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow one unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [7:0] v);
        int remaining;
        remaining = 0;
        for (int i = 0; i < 8; i++) if (v[i]) remaining++;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                exp_q.push_back({(remaining == 1), 3'(i)});
                remaining--;
            end
        end
    endtask

    task automatic offer8(input logic [7:0] v);
        int waited;
        waited = 0;
        while (!in_ready8 && waited < 50) begin
            next_cycle();
            waited++;
        end
        check("offer_in_ready", 16'(in_ready8), 16'd1);
        in_valid8 = 1'b1;
        in_req8   = v;
        push_expected(v);
        next_cycle();
        in_valid8 = 1'b0;
        in_req8   = $urandom_range(0, 255);
        #1;
    endtask

    // Serve the queue; bit c of pat is out_ready on cycle c (1 beyond bit 15).
    task automatic drain8(input string tag, input logic [15:0] pat, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            out_ready8 = (c < 16) ? pat[c] : 1'b1;
            #1;
            check({tag, "_valid"}, 16'(out_valid8), 16'd1);
            check({tag, "_idx_last"}, 16'({out_last8, out_idx8}), 16'(exp_q[0]));
            if (out_ready8) void'(exp_q.pop_front());
            next_cycle();
            c++;
        end
        out_ready8 = 1'b0;
        check({tag, "_drained"}, 16'(exp_q.size()), 16'd0);
        exp_q.delete();
        check({tag, "_idle_valid"}, 16'(out_valid8), 16'd0);
        check({tag, "_idle_busy"}, 16'(busy8), 16'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst         = 1'b1;
        in_valid8   = 1'b0;
        in_req8     = '0;
        out_ready8  = 1'b0;
        in_valid16  = 1'b0;
        in_req16    = '0;
        out_ready16 = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", 16'(out_valid8), 16'd0);
        check("rst_out_idx", 16'(out_idx8), 16'd0);
        check("rst_out_last", 16'(out_last8), 16'd0);
        check("rst_busy", 16'(busy8), 16'd0);
        check("rst_in_ready", 16'(in_ready8), 16'd1);
        check("rst16_out_valid", 16'(out_valid16), 16'd0);
        check("rst16_in_ready", 16'(in_ready16), 16'd1);
`ifdef PRIO_ZERO_ERR_EN
        check("rst_zero_err", 16'(zero_err8), 16'd0);
`endif

        // Single vector, consumer always ready
        offer8(8'b1010_0100);
        drain8("single", 16'hFFFF, 20);

        // Backpressure 1,0,0,1,1,1: indices must hold through the stalls
        offer8(8'b0000_1111);
        drain8("bp", 16'hFFF9, 30);

        // Back-to-back: second vector offered on the last-handshake cycle
        offer8(8'b0000_0001);
        out_ready8 = 1'b1;
        in_valid8  = 1'b1;
        in_req8    = 8'b1000_0000;
        #1;
        check("b2b_in_ready", 16'(in_ready8), 16'd1);
        check("b2b_first", 16'({out_last8, out_idx8}), 16'(exp_q[0]));
        void'(exp_q.pop_front());
        push_expected(8'b1000_0000);
        next_cycle();
        in_valid8 = 1'b0;
        check("b2b_no_bubble", 16'(out_valid8), 16'd1);
        drain8("b2b", 16'hFFFF, 20);

        // Zero vector: accepted and dropped
        in_valid8 = 1'b1;
        in_req8   = 8'h00;
        #1;
        check("zero_in_ready", 16'(in_ready8), 16'd1);
        next_cycle();
        in_valid8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("zero_out_valid", 16'(out_valid8), 16'd0);
            check("zero_in_ready_after", 16'(in_ready8), 16'd1);
            check("zero_busy", 16'(busy8), 16'd0);
`ifdef PRIO_ZERO_ERR_EN
            check("zero_err_sticky", 16'(zero_err8), 16'd1);
`endif
            next_cycle();
        end

        // Reset mid-service after 7, 6, 5
        offer8(8'hFF);
        out_ready8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_idx_last", 16'({out_last8, out_idx8}), 16'(exp_q[0]));
            void'(exp_q.pop_front());
            next_cycle();
        end
        out_ready8 = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        next_cycle();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 16'(out_valid8), 16'd0);
        check("midrst_busy", 16'(busy8), 16'd0);
        check("midrst_in_ready", 16'(in_ready8), 16'd1);
`ifdef PRIO_ZERO_ERR_EN
        check("midrst_zero_err_cleared", 16'(zero_err8), 16'd0);
`endif
        offer8(8'h10);
        drain8("after_rst", 16'hFFFF, 10);

        // WIDTH = 16 instance: 15 then 0
        in_valid16 = 1'b1;
        in_req16   = 16'h8001;
        #1;
        check("w16_in_ready", 16'(in_ready16), 16'd1);
        next_cycle();
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        #1;
        check("w16_first_valid", 16'(out_valid16), 16'd1);
        check("w16_first_idx", 16'(out_idx16), 16'd15);
        check("w16_first_last", 16'(out_last16), 16'd0);
        next_cycle();
        check("w16_second_idx", 16'(out_idx16), 16'd0);
        check("w16_second_last", 16'(out_last16), 16'd1);
        next_cycle();
        out_ready16 = 1'b0;
        check("w16_done_valid", 16'(out_valid16), 16'd0);
        check("w16_done_busy", 16'(busy16), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
